// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, free-running oversample tick, mid-bit sampling FSM,
// and a valid/ready holding register with frame-error pulse and sticky overrun flag.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] tcnt_q;
  logic          tick;
  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          armed_q, armed_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          stop_sample;

  assign tick = (tcnt_q == TICK_LAST);

  // State register plus all datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tcnt_q      <= '0;
      state_q     <= IDLE;
      scnt_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      tcnt_q      <= tick ? '0 : tcnt_q + TW'(1);
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic; armed_q blocks a new start until the line has been seen idle (after break)
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    armed_d  = armed_q;
    if (state_q != IDLE && tick) scnt_d = scnt_q + SW'(1);
    case (state_q)
      IDLE: begin
        scnt_d = '0;
        if (rx_s_q) armed_d = 1'b1;
        if (tick && armed_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (tick && scnt_q == S_MID) begin
          scnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            bitcnt_d = '0;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (tick && scnt_q == S_LAST) begin
          shreg_d  = {rx_s_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && scnt_q == S_LAST) begin
          state_d = IDLE;
          if (!rx_s_q) armed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stop_sample = (state_q == STOP) && tick && (scnt_q == S_LAST);

  // Output logic: a new load takes precedence over a same-cycle accept
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    if (stop_sample) begin
      if (rx_s_q) begin
        if (rx_valid_q && !rx_ready) begin
          overrun_d = 1'b1;
        end else begin
          rx_data_d  = shreg_q;
          rx_valid_d = 1'b1;
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. The clock/baud ratio is scaled down (DIV=6, 96 clk per bit)
// so the full scenario list stays short; sampling behaviour per tick is unchanged.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int TB_CLK  = 1_536_000;
  localparam int TB_BAUD = 16_000;
  localparam int TB_DIV  = 6;
  localparam int BT      = 16 * TB_DIV;   // nominal bit time in clk
  localparam int BT_FAST = 94;            // line 2% fast
  localparam int BT_SLOW = 98;            // line 2% slow

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0;
  int n_xfer = 0;
  int n_ferr = 0;
  int t_rise = 0;
  logic [7:0] last_byte = 8'h00;
  logic valid_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         exp_n;
    logic [7:0] exp_byte;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[12];

  uart_rx #(.CLK_FREQ(TB_CLK), .BAUD(TB_BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observes transfers, frame-error cycles and rx_valid rising edges
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_xfer    <= n_xfer + 1;
      last_byte <= rx_data;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_valid && !valid_prev) t_rise <= cyc;
    valid_prev <= rx_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
    t_start = cyc;
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    drive_bit(stop, bclk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bx, bf;
    vecs[0]  = '{8'h55, 1'b1, BT,      1, 8'h55, 0};
    vecs[1]  = '{8'h55, 1'b1, BT_FAST, 1, 8'h55, 0};
    vecs[2]  = '{8'h55, 1'b1, BT_SLOW, 1, 8'h55, 0};
    vecs[3]  = '{8'h3C, 1'b0, BT,      0, 8'h00, 1};
    vecs[4]  = '{8'h81, 1'b1, BT,      1, 8'h81, 0};
    vecs[5]  = '{8'h3C, 1'b0, BT_FAST, 0, 8'h00, 1};
    vecs[6]  = '{8'h81, 1'b1, BT_FAST, 1, 8'h81, 0};
    vecs[7]  = '{8'h3C, 1'b0, BT_SLOW, 0, 8'h00, 1};
    vecs[8]  = '{8'h81, 1'b1, BT_SLOW, 1, 8'h81, 0};
    vecs[9]  = '{8'h00, 1'b1, BT,      1, 8'h00, 0};
    vecs[10] = '{8'hFF, 1'b1, BT,      1, 8'hFF, 0};
    vecs[11] = '{8'hA5, 1'b1, BT_SLOW, 1, 8'hA5, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(2 * BT);

    // Latency: detection tick lands 3..3+DIV-1 clk after the edge, then 152 ticks to stop sample
    bx = n_xfer;
    send_frame(8'h55, 1'b1, BT);
    idle(2 * BT);
    $display("latency: 0x55 rx_valid rose %0d clk after start edge", t_rise - t_start);
    check("latency_window", int'((t_rise - t_start) >= 3 + 152 * TB_DIV &&
                                 (t_rise - t_start) <= 3 + 152 * TB_DIV + TB_DIV - 1), 1);
    check("latency_xfer_count", n_xfer - bx, 1);

    for (int v = 0; v < 12; v++) begin
      bx = n_xfer;
      bf = n_ferr;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].bclk);
      idle(2 * BT);
      $display("vec %0d: data=0x%0h stop=%0d bclk=%0d xfers=%0d last=0x%0h ferr=%0d ovr=%0d",
               v, vecs[v].data, vecs[v].stop, vecs[v].bclk, n_xfer - bx, last_byte,
               n_ferr - bf, overrun);
      check($sformatf("vec%0d_xfers", v), n_xfer - bx, vecs[v].exp_n);
      if (vecs[v].exp_n > 0) check($sformatf("vec%0d_byte", v), last_byte, vecs[v].exp_byte);
      check($sformatf("vec%0d_ferr_cycles", v), n_ferr - bf, vecs[v].exp_ferr);
      check($sformatf("vec%0d_overrun", v), overrun, 0);
    end

    // Holding register: 0xA3 with consumer stalled, then a one-cycle accept
    rx_ready = 1'b0;
    bx = n_xfer;
    send_frame(8'hA3, 1'b1, BT);
    idle(2 * BT);
    check("hold_valid", rx_valid, 1);
    check("hold_data", rx_data, 8'hA3);
    idle(50);
    check("hold_valid_later", rx_valid, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("accept_clears_valid", rx_valid, 0);
    check("accept_xfer_count", n_xfer - bx, 1);
    $display("hold: 0xA3 held then accepted, xfers=%0d", n_xfer - bx);
    rx_ready = 1'b1;

    // Start glitch of 3 ticks
    bx = n_xfer;
    bf = n_ferr;
    drive_bit(1'b0, 3 * TB_DIV);
    idle(2 * BT);
    check("glitch_no_xfer", n_xfer - bx, 0);
    check("glitch_no_ferr", n_ferr - bf, 0);
    send_frame(8'h5A, 1'b1, BT);
    idle(2 * BT);
    check("glitch_then_byte", last_byte, 8'h5A);
    check("glitch_then_count", n_xfer - bx, 1);
    $display("glitch: xfers=%0d last=0x%0h", n_xfer - bx, last_byte);

    // Break: long low gives a single frame error
    bx = n_xfer;
    bf = n_ferr;
    drive_bit(1'b0, 30 * BT);
    idle(2 * BT);
    check("break_ferr_once", n_ferr - bf, 1);
    check("break_no_xfer", n_xfer - bx, 0);
    send_frame(8'h81, 1'b1, BT);
    idle(2 * BT);
    check("break_then_byte", last_byte, 8'h81);
    $display("break: ferr=%0d last=0x%0h", n_ferr - bf, last_byte);

    // Back-to-back frames with consumer stalled -> overrun
    rx_ready = 1'b0;
    bx = n_xfer;
    send_frame(8'h11, 1'b1, BT);
    send_frame(8'h22, 1'b1, BT);
    idle(2 * BT);
    check("b2b_valid", rx_valid, 1);
    check("b2b_data_first_kept", rx_data, 8'h11);
    check("b2b_overrun", overrun, 1);
    rx_ready = 1'b1;
    send_frame(8'h33, 1'b1, BT);
    idle(2 * BT);
    check("b2b_next_byte", last_byte, 8'h33);
    check("b2b_xfer_count", n_xfer - bx, 2);
    check("b2b_overrun_sticky", overrun, 1);
    $display("b2b: xfers=%0d last=0x%0h ovr=%0d", n_xfer - bx, last_byte, overrun);

    // Reset during data bit 4 of 0xF0
    bx = n_xfer;
    bf = n_ferr;
    fork
      send_frame(8'hF0, 1'b1, BT);
      begin
        repeat (BT * 5 + BT / 2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    idle(2 * BT);
    check("midrst_no_xfer", n_xfer - bx, 0);
    check("midrst_overrun_cleared", overrun, 0);
    send_frame(8'h0F, 1'b1, BT);
    idle(2 * BT);
    check("midrst_xfer_count", n_xfer - bx, 1);
    check("midrst_byte", last_byte, 8'h0F);
    check("midrst_no_ferr", n_ferr - bf, 0);
    check("midrst_overrun", overrun, 0);
    $display("midrst: xfers=%0d last=0x%0h ferr=%0d", n_xfer - bx, last_byte, n_ferr - bf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
